axis_ram_writer: RTL and testbench
==================================

# axis_ram_writer

Stream-to-memory stage that sits directly upstream of the RAM reader in the acquisition/playback chain. It accepts an AXI4-Stream, buffers it in an internal FIFO, and writes it to a circular region of system RAM as fixed 16-beat AXI3 INCR bursts. It reports the index of the next burst to software through `sts_data`. The RAM reader drains the same region using the same `min_addr`/`cfg_data` geometry.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: width of the burst index (`cfg_data`, `sts_data`).
- `AXI_ID_WIDTH`, 6: AXI ID width.
- `AXI_ADDR_WIDTH`, 32: AXI byte address width.
- `AXI_DATA_WIDTH`, 64: AXI data width in bits. Must equal `AXIS_TDATA_WIDTH`.
- `AXIS_TDATA_WIDTH`, 64: stream data width.
- `FIFO_DEPTH`, 512: internal FIFO depth in words. Power of 2, at least 32.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; synchronous, active-low. Clock is `aclk`.
- `min_addr`  in  AXI_ADDR_WIDTH  byte base address of the buffer.
- `cfg_data`  in  ADDR_WIDTH  last valid burst index. The buffer holds `cfg_data+1` bursts.
- `sts_data`  out  ADDR_WIDTH  index of the next burst to be addressed.
- `s_axis_tdata` / `s_axis_tvalid` / `s_axis_tready`  in / in / out  input stream.
- `m_axi_awid`, `m_axi_awlen[3:0]`, `m_axi_awsize[2:0]`, `m_axi_awburst[1:0]`, `m_axi_awcache[3:0]`, `m_axi_awaddr`, `m_axi_awvalid`  out; `m_axi_awready`  in.
- `m_axi_wid`, `m_axi_wdata`, `m_axi_wstrb[AXI_DATA_WIDTH/8]`, `m_axi_wlast`, `m_axi_wvalid`  out; `m_axi_wready`  in.
- `m_axi_bvalid`  in; `m_axi_bready`  out.

## Operation
- Constants:
  - `awid` and `wid` are 0.
  - `awlen` is 15.
  - `awsize` is `ADDR_SIZE = log2(AXI_DATA_WIDTH/8)`.
  - `awburst` is 2'b01 (INCR).
  - `awcache` is 4'b1111.
  - `wstrb` is all ones.
  - `bready` is 1. Write responses are discarded.
- FIFO:
  - Synchronous, first-word-fall-through.
  - Write when `s_axis_tvalid & s_axis_tready`.
  - `s_axis_tready = ~full`.
  - `count` is the number of stored words, width log2(FIFO_DEPTH)+1.
- FSM states: IDLE and BURST.
  - IDLE → BURST when `count >= 16`. On the same edge, assert `awvalid` and clear the beat counter.
  - BURST:
    - `wvalid` = 1. Data is guaranteed because 16 words were present at entry.
    - `wdata` is the FIFO head. FIFO read on `wvalid & wready`.
    - A 4-bit beat counter increments on each W handshake.
    - `wlast` = (beat counter == 15).
  - `awvalid` stays high until `awready`, then drops. The AW and W channels progress independently.
  - BURST → IDLE when both the AW handshake and the `wlast` handshake have completed. They may complete in any order or in the same cycle.
- Address: `awaddr = min_addr + {addr_reg, 4'b0, ADDR_SIZE zeros}`, truncated to AXI_ADDR_WIDTH. The value is held stable while `awvalid` is high.
- On each AW handshake: `addr_reg <= (addr_reg < cfg_data) ? addr_reg+1 : 0`.
- `sts_data = addr_reg`.
- `cfg_data` changed mid-run: takes effect at the next AW handshake. If `addr_reg > cfg_data`, `addr_reg` wraps to 0 at that handshake.

## Timing
- Reset values: `awvalid`=0, `wvalid`=0, `wlast`=0, `sts_data`=0, `s_axis_tready`=0 while `aresetn`=0. FIFO is flushed and the FSM is in IDLE.
- `s_axis_tready` is 1 in the first cycle after reset release.
- Latency: the 16th word is accepted at edge N. `count` reaches 16 at N, so `awvalid`/`wvalid` rise after edge N+1.
- Throughput with `awready`=`wready`=1: 16 W beats, then 1 IDLE cycle, then the next burst. That is 16/17 of the stream rate.
- A FIFO write and read in the same cycle leave `count` unchanged. The input can stream continuously during bursts.
- FIFO full: `tready` = 0. No word is dropped or overwritten.
- Fewer than 16 words never start a burst. The residue waits indefinitely.
- Reset asserted mid-burst: an in-flight AXI transaction is abandoned. The interconnect must be reset with this block.

## Test plan
- Reset, then 16 words 0..15 with `awready`=`wready`=1, `min_addr`=0x1000_0000, `cfg_data`=3 → one burst to 0x1000_0000, 16 beats of data 0..15, `wlast` only on data 15, `sts_data`=1.
- Continuous stream of 80 words with `cfg_data`=3 → burst addresses 0x0, 0x80, 0x100, 0x180, 0x0 (relative to `min_addr`). `sts_data` sequence 1,2,3,0,1.
- `awready` held low 20 cycles, `wready`=1 → all 16 W beats complete first. FSM stays in BURST until `awready`. Address stable throughout. No second burst starts early.
- `wready` toggling 1010…, input at full rate, FIFO_DEPTH=32 → `tready` drops when `count` hits 32. Output data order equals input order with no loss or duplication.
- Input of 15 words → no `awvalid` ever. The 16th word triggers a burst with `awvalid` rising within 2 cycles.
- Reset pulse mid-burst (after beat 7) → all outputs return to reset values next cycle and `sts_data`=0. Fresh 16 words then write to `min_addr`.

Source files
------------

// File: rtl/axis_ram_writer_if.sv
// Stream input and AXI3 write-channel bundle for axis_ram_writer.
// The master modport is the writer side; slave is the stream source and memory side.
interface axis_ram_writer_if #(
  parameter int unsigned AXI_ID_WIDTH     = 6,
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXIS_TDATA_WIDTH = 64
);
  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic                        s_axis_tvalid;
  logic                        s_axis_tready;

  logic [AXI_ID_WIDTH-1:0]     m_axi_awid;
  logic [3:0]                  m_axi_awlen;
  logic [2:0]                  m_axi_awsize;
  logic [1:0]                  m_axi_awburst;
  logic [3:0]                  m_axi_awcache;
  logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic                        m_axi_awvalid;
  logic                        m_axi_awready;

  logic [AXI_ID_WIDTH-1:0]     m_axi_wid;
  logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata;
  logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                        m_axi_wlast;
  logic                        m_axi_wvalid;
  logic                        m_axi_wready;

  logic                        m_axi_bvalid;
  logic                        m_axi_bready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid,
    output s_axis_tready,
    output m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axis_ram_writer.sv
// Buffers an AXI4-Stream in a FWFT FIFO and writes it to a circular RAM region
// as fixed 16-beat AXI3 INCR bursts; sts_data reports the next burst index.
module axis_ram_writer #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned AXI_ID_WIDTH     = 6,
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXIS_TDATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH       = 512
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] min_addr,
  input  logic [ADDR_WIDTH-1:0]     cfg_data,
  output logic [ADDR_WIDTH-1:0]     sts_data,
  axis_ram_writer_if.master         bus
);

  localparam int unsigned ADDR_SIZE = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned STRB_W    = AXI_DATA_WIDTH / 8;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned BURST_LEN = 16;
  localparam int unsigned SHIFT_W   = 4 + ADDR_SIZE;

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t                      r_state;
  logic [AXIS_TDATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [PTR_W-1:0]            r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_tready;
  logic                        r_awvalid;
  logic                        r_wvalid;
  logic                        r_wlast;
  logic                        r_aw_done;
  logic                        r_w_done;
  logic [3:0]                  r_beat;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;

  logic                        w_push;
  logic                        w_pop;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_aw_fin;
  logic                        w_w_fin;
  logic [CNT_W-1:0]            w_count_next;
  logic                        w_unused_bvalid;

  assign w_push       = bus.s_axis_tvalid & r_tready;
  assign w_pop        = r_wvalid & bus.m_axi_wready;
  assign w_aw_hs      = r_awvalid & bus.m_axi_awready;
  assign w_w_hs       = w_pop;
  assign w_aw_fin     = r_aw_done | w_aw_hs;
  assign w_w_fin      = r_w_done | (w_w_hs & r_wlast);
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // Write responses are always accepted and ignored.
  assign w_unused_bvalid = bus.m_axi_bvalid;

  always_ff @(posedge aclk) begin
    if (aresetn && w_push) begin
      r_mem[r_wr_ptr] <= bus.s_axis_tdata;
    end
  end

  // FIFO occupancy; tready is precomputed from the post-edge count so it is
  // low exactly while the FIFO holds FIFO_DEPTH words.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count  <= w_count_next;
      r_tready <= (w_count_next != CNT_W'(FIFO_DEPTH));
    end
  end

  // Burst sequencer: AW and W progress independently, the burst closes once both finish.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wlast   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_beat    <= 4'd0;
      r_addr    <= '0;
      r_awaddr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_count >= CNT_W'(BURST_LEN)) begin
            r_state   <= ST_BURST;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_wlast   <= 1'b0;
            r_beat    <= 4'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= min_addr
                       + AXI_ADDR_WIDTH'({r_addr, {SHIFT_W{1'b0}}});
          end
        end
        ST_BURST: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_addr    <= (r_addr < cfg_data) ? r_addr + ADDR_WIDTH'(1) : '0;
          end
          if (w_w_hs) begin
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
            end else begin
              r_beat  <= r_beat + 4'd1;
              r_wlast <= (r_beat == 4'd14);
            end
          end
          if (w_aw_fin && w_w_fin) begin
            r_state   <= ST_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_fin;
            r_w_done  <= w_w_fin;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sts_data           = r_addr;
  assign bus.s_axis_tready  = r_tready;

  assign bus.m_axi_awid     = AXI_ID_WIDTH'(0);
  assign bus.m_axi_awlen    = 4'd15;
  assign bus.m_axi_awsize   = 3'(ADDR_SIZE);
  assign bus.m_axi_awburst  = 2'b01;
  assign bus.m_axi_awcache  = 4'b1111;
  assign bus.m_axi_awaddr   = r_awaddr;
  assign bus.m_axi_awvalid  = r_awvalid;

  assign bus.m_axi_wid      = AXI_ID_WIDTH'(0);
  assign bus.m_axi_wdata    = r_mem[r_rd_ptr];
  assign bus.m_axi_wstrb    = {STRB_W{1'b1}};
  assign bus.m_axi_wlast    = r_wlast;
  assign bus.m_axi_wvalid   = r_wvalid;

  assign bus.m_axi_bready   = 1'b1;

endmodule

// File: tb/tb_axis_ram_writer.sv
// Directed bench for axis_ram_writer: a queue model of the FIFO plus a burst-index
// model is compared against the AXI outputs every cycle, with literal checks per scenario.
module tb_axis_ram_writer;
  localparam int unsigned AW    = 16;
  localparam int unsigned IDW   = 6;
  localparam int unsigned AAW   = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 32;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [AAW-1:0] min_addr;
  logic [AW-1:0]  cfg_data;
  logic [AW-1:0]  sts_data;

  axis_ram_writer_if #(
    .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AAW),
    .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(DW)
  ) bus ();

  axis_ram_writer #(
    .ADDR_WIDTH(AW), .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AAW),
    .AXI_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .min_addr(min_addr),
    .cfg_data(cfg_data), .sts_data(sts_data), .bus(bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus controls
  logic [DW-1:0] src_q[$];
  bit            aw_hold   = 1'b0;
  bit            wr_toggle = 1'b0;

  // Model state and observation logs
  logic [DW-1:0]  exp_q[$];
  logic [AAW-1:0] aw_log[$];
  logic [AW-1:0]  sts_log[$];
  int unsigned    idx = 0;
  int unsigned    beat = 0;
  int             beats_total = 0;
  int             aw_total = 0;
  int             wlast_total = 0;
  int             acc_total = 0;
  int             cyc = 0;
  int             last_acc_cyc = 0;
  int             aw_rise_cyc = 0;
  bit             saw_full = 1'b0;
  bit             sts_pending = 1'b0;
  logic [DW-1:0]  last_wlast_data = '0;
  int             last_edge = -1;

  always @(posedge aclk) last_edge <= aresetn ? 0 : 1;

  // Drives the stream source and the ready patterns just after each rising edge.
  initial begin : driver
    bit src_hs;
    bit w_tog;
    w_tog = 1'b0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.m_axi_awready = 1'b1;
    bus.m_axi_wready  = 1'b1;
    bus.m_axi_bvalid  = 1'b0;
    forever begin
      @(negedge aclk);
      src_hs = bus.s_axis_tvalid && bus.s_axis_tready && aresetn;
      @(posedge aclk);
      #1;
      if (src_hs && src_q.size() > 0) void'(src_q.pop_front());
      bus.s_axis_tvalid = (src_q.size() > 0);
      bus.s_axis_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
      w_tog = ~w_tog;
      bus.m_axi_wready  = wr_toggle ? w_tog : 1'b1;
      bus.m_axi_awready = ~aw_hold;
    end
  end

  // Compare process: samples on the falling edge what the next rising edge will see.
  initial begin : monitor
    bit             prev_held;
    logic [AAW-1:0] prev_awaddr;
    logic [AAW-1:0] exp_addr;
    prev_held   = 1'b0;
    prev_awaddr = '0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (last_edge == 1) begin
        chk("rst_awvalid", bus.m_axi_awvalid, 0);
        chk("rst_wvalid",  bus.m_axi_wvalid, 0);
        chk("rst_wlast",   bus.m_axi_wlast, 0);
        chk("rst_sts",     sts_data, 0);
        chk("rst_tready",  bus.s_axis_tready, 0);
      end else if (last_edge == 0) begin
        if (sts_pending) begin
          sts_log.push_back(sts_data);
          sts_pending = 1'b0;
        end
        chk("tready_vs_occupancy", bus.s_axis_tready, (exp_q.size() != DEPTH));
        chk("sts_data", sts_data, idx);
        chk("bready", bus.m_axi_bready, 1);
        if (bus.m_axi_wvalid) chk("wlast_position", bus.m_axi_wlast, (beat == 15));
        if (bus.m_axi_awvalid && prev_held) chk("awaddr_stable", bus.m_axi_awaddr, prev_awaddr);
        if (!bus.s_axis_tready) saw_full = 1'b1;
        if (bus.m_axi_awvalid && !prev_held) aw_rise_cyc = cyc;
        if (aresetn) begin
          if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL w_underflow: got beat 0x%0h, expected no beat (model empty)", bus.m_axi_wdata);
            end else begin
              chk("wdata", bus.m_axi_wdata, exp_q.pop_front());
            end
            chk("wstrb", bus.m_axi_wstrb, 8'hFF);
            chk("wid", bus.m_axi_wid, 0);
            if (bus.m_axi_wlast) begin
              last_wlast_data = bus.m_axi_wdata;
              wlast_total++;
            end
            beat = (beat + 1) % 16;
            beats_total++;
          end
          if (bus.s_axis_tvalid && bus.s_axis_tready) begin
            exp_q.push_back(bus.s_axis_tdata);
            acc_total++;
            last_acc_cyc = cyc;
          end
          if (bus.m_axi_awvalid && bus.m_axi_awready) begin
            exp_addr = min_addr + AAW'(idx) * 32'd128;
            chk("awaddr", bus.m_axi_awaddr, exp_addr);
            chk("awlen", bus.m_axi_awlen, 15);
            chk("awsize", bus.m_axi_awsize, 3);
            chk("awburst", bus.m_axi_awburst, 1);
            chk("awcache", bus.m_axi_awcache, 15);
            chk("awid", bus.m_axi_awid, 0);
            aw_log.push_back(bus.m_axi_awaddr);
            idx = (idx < cfg_data) ? idx + 1 : 0;
            aw_total++;
            sts_pending = 1'b1;
          end
        end
        prev_held   = bus.m_axi_awvalid && !bus.m_axi_awready;
        prev_awaddr = bus.m_axi_awaddr;
      end
      if (!aresetn) begin
        exp_q.delete();
        idx         = 0;
        beat        = 0;
        prev_held   = 1'b0;
        sts_pending = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within 1 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats_total < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, beats_total, target);
  endtask

  task automatic wait_aw(input int target, input int budget, input string name);
    int n = 0;
    while (aw_total < target && n < budget) begin
      tick();
      n++;
    end
    chk(name, aw_total, target);
  endtask

  task automatic push_words(input int n, input logic [DW-1:0] first);
    for (int i = 0; i < n; i++) src_q.push_back(first + DW'(i));
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_awvalid", bus.m_axi_awvalid, 0);
    chk("reset_sts", sts_data, 0);
    aresetn = 1'b1;
  endtask

  initial begin : main
    int base_b;
    int base_a;
    int base_acc;
    logic [AAW-1:0] exp_aw [5];
    logic [AW-1:0]  exp_sts [5];
    exp_aw  = '{32'h0, 32'h80, 32'h100, 32'h180, 32'h0};
    exp_sts = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};

    cfg_data = 16'd3;
    min_addr = 32'h1000_0000;

    // Power-on reset
    repeat (3) @(posedge aclk);
    #1;
    chk("por_awvalid", bus.m_axi_awvalid, 0);
    chk("por_wvalid", bus.m_axi_wvalid, 0);
    chk("por_wlast", bus.m_axi_wlast, 0);
    chk("por_sts", sts_data, 0);
    chk("por_tready", bus.s_axis_tready, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("tready_after_release", bus.s_axis_tready, 1);

    // Single burst of 0..15
    push_words(16, 64'd0);
    wait_aw(1, 100, "t1_aw_count");
    wait_beats(16, 100, "t1_beats");
    tick();
    chk("t1_addr", aw_log[0], 32'h1000_0000);
    chk("t1_wlast_data", last_wlast_data, 64'd15);
    chk("t1_wlast_count", wlast_total, 1);
    chk("t1_latency", aw_rise_cyc - last_acc_cyc, 2);
    chk("t1_sts", sts_data, 1);

    // 80-word continuous stream wrapping over 4 bursts
    min_addr = 32'h0;
    do_reset();
    aw_log.delete();
    sts_log.delete();
    base_b = beats_total;
    base_a = aw_total;
    push_words(80, 64'd100);
    wait_beats(base_b + 80, 400, "t2_beats");
    wait_aw(base_a + 5, 20, "t2_aw_count");
    tick();
    chk("t2_aw_log_size", aw_log.size(), 5);
    chk("t2_sts_log_size", sts_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < aw_log.size()) chk("t2_aw_addr", aw_log[i], exp_aw[i]);
      if (i < sts_log.size()) chk("t2_sts_seq", sts_log[i], exp_sts[i]);
    end

    // AW stalled while W completes; second burst must wait
    aw_hold = 1'b1;
    base_b = beats_total;
    base_a = aw_total;
    push_words(32, 64'd200);
    wait_beats(base_b + 16, 100, "t3_w_first");
    repeat (8) tick();
    chk("t3_awvalid_held", bus.m_axi_awvalid, 1);
    chk("t3_awaddr_held", bus.m_axi_awaddr, 32'h80);
    chk("t3_wvalid_low", bus.m_axi_wvalid, 0);
    chk("t3_no_second_burst", beats_total, base_b + 16);
    chk("t3_no_aw_yet", aw_total, base_a);
    aw_hold = 1'b0;
    wait_aw(base_a + 2, 100, "t3_aw_count");
    wait_beats(base_b + 32, 100, "t3_beats");
    if (aw_log.size() >= 7) begin
      chk("t3_addr0", aw_log[5], 32'h80);
      chk("t3_addr1", aw_log[6], 32'h100);
    end else begin
      chk("t3_aw_log_size", aw_log.size(), 7);
    end

    // Half-rate W against full-rate input fills the FIFO
    wr_toggle = 1'b1;
    saw_full  = 1'b0;
    base_b    = beats_total;
    base_acc  = acc_total;
    push_words(96, 64'h1000);
    wait_beats(base_b + 96, 1000, "t4_beats");
    wr_toggle = 1'b0;
    chk("t4_tready_dropped", saw_full, 1);
    chk("t4_accepted", acc_total - base_acc, 96);
    chk("t4_model_drained", exp_q.size(), 0);

    // 15 words never start a burst; the 16th does
    base_a = aw_total;
    base_b = beats_total;
    push_words(15, 64'h2000);
    repeat (40) tick();
    chk("t5_no_aw", aw_total, base_a);
    chk("t5_awvalid_low", bus.m_axi_awvalid, 0);
    push_words(1, 64'h200F);
    wait_aw(base_a + 1, 20, "t5_aw_count");
    chk("t5_latency", aw_rise_cyc - last_acc_cyc, 2);
    wait_beats(base_b + 16, 100, "t5_beats");
    tick();
    chk("t5_last_data", last_wlast_data, 64'h200F);

    // Reset in the middle of a burst
    base_b = beats_total;
    push_words(16, 64'h3000);
    wait_beats(base_b + 8, 100, "t6_mid_burst");
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("t6_awvalid", bus.m_axi_awvalid, 0);
    chk("t6_wvalid", bus.m_axi_wvalid, 0);
    chk("t6_wlast", bus.m_axi_wlast, 0);
    chk("t6_sts", sts_data, 0);
    chk("t6_tready", bus.s_axis_tready, 0);
    aresetn  = 1'b1;
    min_addr = 32'h2000_0000;
    aw_log.delete();
    base_a = aw_total;
    base_b = beats_total;
    push_words(16, 64'h4000);
    wait_aw(base_a + 1, 100, "t6_aw_count");
    wait_beats(base_b + 16, 100, "t6_beats");
    tick();
    if (aw_log.size() >= 1) chk("t6_addr", aw_log[0], 32'h2000_0000);
    else chk("t6_aw_log_size", aw_log.size(), 1);
    chk("t6_last_data", last_wlast_data, 64'h400F);
    chk("t6_sts_after", sts_data, 1);

    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
